alu_op_seq: RTL and testbench

ALU_OP_SEQ -- requirements
Module: alu_op_seq

---
 rtl/alu_op_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_op_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_seq.sv
// Queues ALU operations, drives them onto an external combinational ALU, waits a
// fixed settle time, then captures and holds the result until downstream accepts it.
module alu_op_seq #(
    parameter int N      = 64,
    parameter int DEPTH  = 2,
    parameter int SETTLE = 3
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_A,
    input  logic [N-1:0] in_B,
    input  logic [3:0]   in_ctrl,
    output logic [N-1:0] alu_BusA,
    output logic [N-1:0] alu_BusB,
    output logic [3:0]   alu_ALUCtrl,
    input  logic [N-1:0] alu_result,
    input  logic         alu_Zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_zero,
    output logic [3:0]   out_ctrl,
    output logic         out_illegal
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int EW   = 2 * N + 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;
    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    bus_a_q, bus_a_d;
    logic [N-1:0]    bus_b_q, bus_b_d;
    logic [3:0]      bus_ctrl_q, bus_ctrl_d;
    logic [N-1:0]    res_q, res_d;
    logic            zero_q, zero_d;
    logic [3:0]      octrl_q, octrl_d;
    logic            ill_q, ill_d;

    logic push, launch, not_empty, legal;

    always_comb begin
        case (bus_ctrl_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0110, 4'b0111: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
    end

    always_comb begin
        push      = in_valid && ready_q;
        not_empty = (count_q != '0);
        // Launch only from registered occupancy, so a push into an empty queue waits one edge.
        launch    = not_empty && ((state_q == S_IDLE) || (state_q == S_HOLD && out_ready));

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_a_d    = bus_a_q;
        bus_b_d    = bus_b_q;
        bus_ctrl_d = bus_ctrl_q;
        res_d      = res_q;
        zero_d     = zero_q;
        octrl_d    = octrl_q;
        ill_d      = ill_q;

        case (state_q)
            S_IDLE: ;
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    res_d   = legal ? alu_result : '0;
                    zero_d  = legal ? alu_Zero : 1'b1;
                    octrl_d = bus_ctrl_q;
                    ill_d   = !legal;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            {bus_a_d, bus_b_d, bus_ctrl_d} = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = CNTW'(SETTLE - 1);
            state_d  = S_SETTLE;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        case ({push, launch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (push && !Reset) mem_q[wr_ptr_q] <= {in_A, in_B, in_ctrl};
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bus_a_q    <= '0;
            bus_b_q    <= '0;
            bus_ctrl_q <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            octrl_q    <= '0;
            ill_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_a_q    <= bus_a_d;
            bus_b_q    <= bus_b_d;
            bus_ctrl_q <= bus_ctrl_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            octrl_q    <= octrl_d;
            ill_q      <= ill_d;
        end
    end

    assign in_ready    = ready_q;
    assign alu_BusA    = bus_a_q;
    assign alu_BusB    = bus_b_q;
    assign alu_ALUCtrl = bus_ctrl_q;
    assign out_valid   = (state_q == S_HOLD);
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_ctrl    = octrl_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Directed and randomized checks of alu_op_seq against a queue-based reference
// model, with a combinational ALU modelled in the bench.
module tb_alu_op_seq;

    localparam int N = 64;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_A, in_B;
    logic [3:0]   in_ctrl;
    logic [N-1:0] alu_BusA, alu_BusB;
    logic [3:0]   alu_ALUCtrl;
    logic [N-1:0] alu_result;
    logic         alu_Zero;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_zero;
    logic [3:0]   out_ctrl;
    logic         out_illegal;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
    } op_t;
    op_t q[$];

    alu_op_seq #(.N(N), .DEPTH(2), .SETTLE(3)) dut (
        .CLK(CLK), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_ctrl(in_ctrl),
        .alu_BusA(alu_BusA), .alu_BusB(alu_BusB), .alu_ALUCtrl(alu_ALUCtrl),
        .alu_result(alu_result), .alu_Zero(alu_Zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    always #5 CLK = ~CLK;

    // Undefined codes make the ALU produce a non-zero value so ignoring it is observable.
    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a << b;
            4'd4:    return a >> b;
            4'd6:    return a - b;
            4'd7:    return b;
            default: return '1;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_BusA, alu_BusB, alu_ALUCtrl);
        alu_Zero   = (alu_result == '0);
    end

    function automatic bit is_legal(input logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        in_valid = 1'b1;
        in_A     = a;
        in_B     = b;
        in_ctrl  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int unsigned k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic model_step(input bit allow_push);
        bit          do_push, do_pop, was_hold;
        logic [63:0] prev_res, exp_res;
        bit          ill;
        if (allow_push) begin
            in_valid = 1'($urandom_range(0, 1));
            in_ctrl  = 4'($urandom_range(0, 15));
            in_A     = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) in_B = in_A;
            else if (in_ctrl == 4'd3 || in_ctrl == 4'd4) in_B = 64'($urandom_range(0, 70));
            else in_B = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        do_push = in_valid && in_ready;
        do_pop  = out_valid && out_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("rnd_unexpected_valid", out_valid, 0);
            end else begin
                ill     = !is_legal(q[0].c);
                exp_res = ill ? 64'd0 : alu_fn(q[0].a, q[0].b, q[0].c);
                chk("rnd_result", out_result, exp_res);
                chk("rnd_zero", out_zero, ill ? 1 : (exp_res == 0));
                chk("rnd_illegal", out_illegal, ill);
                chk("rnd_ctrl", out_ctrl, q[0].c);
                chk("rnd_busA", alu_BusA, q[0].a);
                chk("rnd_busB", alu_BusB, q[0].b);
            end
        end
        was_hold = out_valid && !out_ready;
        prev_res = out_result;
        tick();
        if (do_push) q.push_back('{a: in_A, b: in_B, c: in_ctrl});
        if (do_pop && q.size() > 0) void'(q.pop_front());
        if (was_hold) begin
            chk("rnd_hold_valid", out_valid, 1);
            chk("rnd_hold_result", out_result, prev_res);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        int seen;
        int stale;
        int unsigned k;

        Reset = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; in_ctrl = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_busA", alu_BusA, 0);
        chk("rst_busB", alu_BusB, 0);
        chk("rst_alu_ctrl", alu_ALUCtrl, 0);
        Reset = 1'b0;
        tick();
        chk("ready_after_reset", in_ready, 1);

        // ADD timing: push at P, launch at P+1, valid after P+4
        out_ready = 1'b1;
        push(64'd5, 64'd7, 4'b0010);
        chk("add_no_same_edge_launch", alu_BusA, 0);
        chk("add_valid_P", out_valid, 0);
        tick();
        chk("add_busA", alu_BusA, 5);
        chk("add_busB", alu_BusB, 7);
        chk("add_alu_ctrl", alu_ALUCtrl, 4'b0010);
        tick(); tick();
        chk("add_valid_P3", out_valid, 0);
        tick();
        chk("add_valid_P4", out_valid, 1);
        chk("add_result", out_result, 12);
        chk("add_zero", out_zero, 0);
        chk("add_illegal", out_illegal, 0);
        chk("add_ctrl", out_ctrl, 4'b0010);
        tick();
        chk("add_consumed", out_valid, 0);

        push(64'h00000000DEADBEEF, 64'h00000000DEADBEEF, 4'b0110);
        wait_valid("sub_valid");
        chk("sub_result", out_result, 0);
        chk("sub_zero", out_zero, 1);
        chk("sub_illegal", out_illegal, 0);
        tick();

        push(64'd3, 64'd4, 4'b0101);
        wait_valid("ill_valid");
        chk("ill_flag", out_illegal, 1);
        chk("ill_result", out_result, 0);
        chk("ill_zero", out_zero, 1);
        chk("ill_ctrl", out_ctrl, 4'b0101);
        tick();

        // Backpressure
        out_ready = 1'b0;
        tick(); tick();
        chk("bp_idle", out_valid, 0);
        push(64'd1, 64'd4, 4'b0011);
        chk("bp_ready1", in_ready, 1);
        push(64'd8, 64'd1, 4'b0001);
        chk("bp_ready2", in_ready, 1);
        push(64'd0, 64'd9, 4'b0111);
        chk("bp_ready_full", in_ready, 0);
        wait_valid("bp_valid1");
        chk("bp_r1", out_result, 16);
        tick(); tick(); tick();
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_result", out_result, 16);
        chk("bp_hold_full", in_ready, 0);
        out_ready = 1'b1;
        seen = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) chk("bp_ready_after_pop", in_ready, 1);
            if (out_valid) begin
                if (seen == 0) begin
                    chk("bp_t2", 64'(t), 4);
                    chk("bp_r2", out_result, 9);
                    chk("bp_c2", out_ctrl, 4'b0001);
                end else begin
                    chk("bp_t3", 64'(t), 8);
                    chk("bp_r3", out_result, 9);
                    chk("bp_c3", out_ctrl, 4'b0111);
                end
                seen++;
            end
        end
        chk("bp_count", 64'(seen), 2);

        // Reset during SETTLE with a queued op and a simultaneous push
        push(64'd100, 64'd200, 4'b0010);
        push(64'd1, 64'd1, 4'b0010);
        chk("mid_launched", alu_BusA, 100);
        Reset = 1'b1; in_valid = 1'b1; in_A = 64'd55; in_B = 64'd1; in_ctrl = 4'b0010;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busA", alu_BusA, 0);
        chk("mid_rst_alu_ctrl", alu_ALUCtrl, 0);
        chk("mid_rst_ready", in_ready, 0);
        Reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("mid_post_ready", in_ready, 1);
        chk("mid_post_valid", out_valid, 0);
        chk("mid_post_busA", alu_BusA, 0);
        chk("mid_post_busB", alu_BusB, 0);
        stale = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("mid_no_stale", 64'(stale), 0);
        chk("mid_no_launch", alu_BusA, 0);

        q.delete();
        for (int i = 0; i < 400; i++) model_step(1'b1);
        k = 0;
        while ((q.size() > 0 || out_valid) && k < 200) begin
            model_step(1'b0);
            k++;
        end
        chk("drain_empty", 64'(q.size()), 0);
        chk("drain_idle", out_valid, 0);
        chk("drain_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
